clock_mode_ctrl: RTL and testbench

//  Sequencer for the alarm clock's cascaded Mod_N_Counter chain (sec units/tens, min units/tens, hours)
//  and the alarm min/hr counters. Owns the mode FSM, derives every counter's en and up/down,

---
 rtl/clock_ctrl_pkg.sv | 41 ++++
 rtl/carry_decode.sv | 34 +++
 rtl/clock_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_clock_mode_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_ctrl_pkg.sv
// ============================================================================
// Module : clock_ctrl_pkg
// Brief  : Shared mode encoding, counter limits and enable-vector indices.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_MIN = 3'd1,
    SET_HR  = 3'd2,
    ALM_MIN = 3'd3,
    ALM_HR  = 3'd4
  } mode_t;

  localparam logic [3:0] UNITS_MAX = 4'd9;
  localparam logic [2:0] TENS_MAX  = 3'd5;

  localparam int EN_SEC_U   = 0;
  localparam int EN_SEC_T   = 1;
  localparam int EN_MIN_U   = 2;
  localparam int EN_MIN_T   = 3;
  localparam int EN_HR      = 4;
  localparam int ALM_EN_MIN = 0;
  localparam int ALM_EN_HR  = 1;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     next_mode = SET_MIN;
      SET_MIN: next_mode = SET_HR;
      SET_HR:  next_mode = ALM_MIN;
      ALM_MIN: next_mode = ALM_HR;
      default: next_mode = RUN;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/carry_decode.sv
// ============================================================================
// Module : carry_decode
// Brief  : Terminal-count decode of the sec/min counter cascade.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module carry_decode
  import clock_ctrl_pkg::*;
(
  input  logic [3:0] sec_u,
  input  logic [2:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [2:0] min_t,
  input  logic       count_up,
  output logic [4:0] run_en,
  output logic       min_t_step
);

  // run_en is the running-clock cascade, qualified by tick in the caller
  always_comb begin
    run_en           = '0;
    run_en[EN_SEC_U] = 1'b1;
    run_en[EN_SEC_T] = (sec_u == UNITS_MAX);
    run_en[EN_MIN_U] = run_en[EN_SEC_T] && (sec_t == TENS_MAX);
    run_en[EN_MIN_T] = run_en[EN_MIN_U] && (min_u == UNITS_MAX);
    run_en[EN_HR]    = run_en[EN_MIN_T] && (min_t == TENS_MAX);
  end

  assign min_t_step = count_up ? (min_u == UNITS_MAX) : (min_u == 4'd0);

endmodule

`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
// ============================================================================
// Module : clock_mode_ctrl
// Brief  : Mode FSM and enable/direction sequencer for the alarm-clock counters.
//          Optional macro AUTO_EXIT_EN adds an idle timeout back to RUN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int HR_MOD = 24
`ifdef AUTO_EXIT_EN
  , parameter int IDLE_S = 10
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] sec_u,
  input  logic [2:0] sec_t,
  input  logic [3:0] min_u,
  input  logic [2:0] min_t,
  input  logic [4:0] hr,
  input  logic [5:0] alm_min,
  input  logic [4:0] alm_hr,
  output logic [4:0] cnt_en,
  output logic [1:0] alm_en,
  output logic       up_dn,
  output logic [2:0] mode,
  output logic       alarm_hit
);

  mode_t      mode_q;
  logic       alarm_hit_q;
  logic       alarm_hit_d;
  logic       up_ok;
  logic       dn_ok;
  logic [4:0] run_en;
  logic       min_t_step;
  logic [5:0] min_bin;
  logic [5:0] next_min;
  logic [4:0] next_hr;
  logic       min_wrap;

  assign up_ok = btn_up & ~btn_down & ~btn_mode;
  assign dn_ok = btn_down & ~btn_up & ~btn_mode;

  carry_decode u_carry (
    .sec_u      (sec_u),
    .sec_t      (sec_t),
    .min_u      (min_u),
    .min_t      (min_t),
    .count_up   (~dn_ok),
    .run_en     (run_en),
    .min_t_step (min_t_step)
  );

  always_comb begin
    cnt_en = '0;
    alm_en = '0;
    up_dn  = 1'b1;
    if (!rst) begin
      case (mode_q)
        RUN: if (tick_1hz) cnt_en = run_en;
        SET_MIN: if (up_ok || dn_ok) begin
          cnt_en[EN_MIN_U] = 1'b1;
          cnt_en[EN_MIN_T] = min_t_step;
          up_dn            = up_ok;
        end
        SET_HR: if (up_ok || dn_ok) begin
          cnt_en[EN_HR] = 1'b1;
          up_dn         = up_ok;
        end
        ALM_MIN, ALM_HR: begin
          if (tick_1hz) cnt_en = run_en;
          // up_dn is shared: a down press colliding with a tick would reverse the time chain
          if (up_ok || (dn_ok && !tick_1hz)) begin
            if (mode_q == ALM_MIN) alm_en[ALM_EN_MIN] = 1'b1;
            else                   alm_en[ALM_EN_HR]  = 1'b1;
            up_dn = up_ok;
          end
        end
        default: ;
      endcase
    end
  end

  assign min_bin  = 6'(min_t) * 6'd10 + 6'(min_u);
  assign min_wrap = (min_bin == 6'd59);
  assign next_min = min_wrap ? 6'd0 : min_bin + 6'd1;
  assign next_hr  = !min_wrap ? hr : ((hr == 5'(HR_MOD - 1)) ? 5'd0 : hr + 5'd1);

  assign alarm_hit_d = (mode_q == RUN) && tick_1hz && run_en[EN_MIN_U] &&
                       (next_min == alm_min) && (next_hr == alm_hr);

`ifdef AUTO_EXIT_EN
  localparam int IDLE_W = $clog2(IDLE_S + 1);
  logic [IDLE_W-1:0] idle_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= RUN;
      alarm_hit_q <= 1'b0;
`ifdef AUTO_EXIT_EN
      idle_q      <= '0;
`endif
    end else begin
      alarm_hit_q <= alarm_hit_d;
      if (btn_mode) mode_q <= next_mode(mode_q);
`ifdef AUTO_EXIT_EN
      if (mode_q == RUN || btn_mode || btn_up || btn_down) begin
        idle_q <= '0;
      end else if (tick_1hz) begin
        if (idle_q == IDLE_W'(IDLE_S - 1)) begin
          mode_q <= RUN;
          idle_q <= '0;
        end else begin
          idle_q <= idle_q + IDLE_W'(1);
        end
      end
`endif
    end
  end

  assign mode      = mode_q;
  assign alarm_hit = alarm_hit_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
// ============================================================================
// Module : tb_clock_mode_ctrl
// Brief  : Directed vector table plus hand sequences for clock_mode_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clock_mode_ctrl;
  import clock_ctrl_pkg::*;

  logic       clk, rst, tick_1hz, btn_mode, btn_up, btn_down;
  logic [3:0] sec_u, min_u;
  logic [2:0] sec_t, min_t;
  logic [4:0] hr, alm_hr;
  logic [5:0] alm_min;
  logic [4:0] cnt_en;
  logic [1:0] alm_en;
  logic       up_dn, alarm_hit;
  logic [2:0] mode;

  int checks = 0;
  int failures = 0;

  clock_mode_ctrl #(.HR_MOD(24)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_up(btn_up), .btn_down(btn_down), .sec_u(sec_u), .sec_t(sec_t),
    .min_u(min_u), .min_t(min_t), .hr(hr), .alm_min(alm_min), .alm_hr(alm_hr),
    .cnt_en(cnt_en), .alm_en(alm_en), .up_dn(up_dn), .mode(mode), .alarm_hit(alarm_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         nmode;
    logic       tick, up, dn, bm;
    logic [3:0] su;
    logic [2:0] st;
    logic [3:0] mu;
    logic [2:0] mt;
    logic [4:0] h;
    logic [4:0] e_cnt;
    logic [1:0] e_alm;
    logic       e_ud;
    logic [2:0] e_mode;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [4:0] h, input logic [2:0] mt, input logic [3:0] mu,
                          input logic [2:0] st, input logic [3:0] su);
    hr = h; min_t = mt; min_u = mu; sec_t = st; sec_u = su;
  endtask

  task automatic clear_inputs();
    tick_1hz = 0; btn_mode = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic go_mode(input int n);
    clear_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    for (int k = 0; k < n; k++) begin
      btn_mode = 1;
      step();
      btn_mode = 0;
    end
  endtask

  task automatic tick_pulse();
    tick_1hz = 1;
    step();
    tick_1hz = 0;
    step();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    set_time(0, 0, 0, 0, 0);
    alm_min = 6'd63;
    alm_hr  = 5'd31;

    //            mode tk up dn bm  su st mu mt  hr   cnt       alm    ud  mode'
    vecs[0]  = '{0, 1, 0, 0, 0, 9, 5, 9, 5, 0,  5'b11111, 2'b00, 1, 3'd0};
    vecs[1]  = '{0, 1, 0, 0, 0, 9, 5, 9, 5, 23, 5'b11111, 2'b00, 1, 3'd0};
    vecs[2]  = '{0, 1, 0, 0, 0, 8, 5, 4, 3, 12, 5'b00001, 2'b00, 1, 3'd0};
    vecs[3]  = '{0, 0, 0, 0, 0, 8, 5, 4, 3, 12, 5'b00000, 2'b00, 1, 3'd0};
    vecs[4]  = '{0, 1, 0, 0, 0, 9, 5, 4, 3, 12, 5'b00111, 2'b00, 1, 3'd0};
    vecs[5]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 5,  5'b01100, 2'b00, 0, 3'd1};
    vecs[6]  = '{1, 0, 1, 0, 0, 0, 0, 9, 3, 5,  5'b01100, 2'b00, 1, 3'd1};
    vecs[7]  = '{1, 0, 1, 0, 0, 0, 0, 4, 3, 5,  5'b00100, 2'b00, 1, 3'd1};
    vecs[8]  = '{1, 1, 0, 0, 0, 9, 5, 9, 5, 5,  5'b00000, 2'b00, 1, 3'd1};
    vecs[9]  = '{2, 0, 1, 0, 0, 0, 0, 0, 0, 5,  5'b10000, 2'b00, 1, 3'd2};
    vecs[10] = '{2, 0, 0, 1, 0, 0, 0, 0, 0, 5,  5'b10000, 2'b00, 0, 3'd2};
    vecs[11] = '{2, 0, 1, 1, 0, 0, 0, 0, 0, 5,  5'b00000, 2'b00, 1, 3'd2};
    vecs[12] = '{2, 0, 1, 0, 1, 0, 0, 0, 0, 5,  5'b00000, 2'b00, 1, 3'd3};
    vecs[13] = '{3, 0, 1, 0, 0, 0, 0, 0, 0, 5,  5'b00000, 2'b01, 1, 3'd3};
    vecs[14] = '{4, 0, 0, 1, 0, 0, 0, 0, 0, 5,  5'b00000, 2'b10, 0, 3'd4};
    vecs[15] = '{3, 1, 0, 0, 0, 9, 0, 0, 0, 0,  5'b00011, 2'b00, 1, 3'd3};
    vecs[16] = '{4, 1, 1, 0, 0, 0, 0, 0, 0, 0,  5'b00001, 2'b10, 1, 3'd4};

    // Reset: enables forced low even with active inputs
    tick_1hz = 1; btn_up = 1;
    set_time(0, 5, 9, 5, 9);
    #1;
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_alm_en", 32'(alm_en), 32'd0);
    check("rst_up_dn", 32'(up_dn), 32'd1);
    step();
    check("rst_mode", 32'(mode), 32'(RUN));
    check("rst_alarm_hit", 32'(alarm_hit), 32'd0);

    for (int i = 0; i < 17; i++) begin
      go_mode(vecs[i].nmode);
      set_time(vecs[i].h, vecs[i].mt, vecs[i].mu, vecs[i].st, vecs[i].su);
      tick_1hz = vecs[i].tick; btn_up = vecs[i].up;
      btn_down = vecs[i].dn;   btn_mode = vecs[i].bm;
      #1;
      check($sformatf("v%0d_cnt_en", i), 32'(cnt_en), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d_alm_en", i), 32'(alm_en), 32'(vecs[i].e_alm));
      check($sformatf("v%0d_up_dn", i), 32'(up_dn), 32'(vecs[i].e_ud));
      step();
      clear_inputs();
      check($sformatf("v%0d_mode", i), 32'(mode), 32'(vecs[i].e_mode));
    end

    // Alarm at 07:30 reached from 07:29:59
    go_mode(0);
    alm_min = 6'd30; alm_hr = 5'd7;
    set_time(7, 2, 9, 5, 9);
    tick_1hz = 1;
    #1;
    check("alarm_pre", 32'(alarm_hit), 32'd0);
    step();
    tick_1hz = 0;
    set_time(7, 3, 0, 0, 0);
    check("alarm_hit", 32'(alarm_hit), 32'd1);
    step();
    check("alarm_one_cycle", 32'(alarm_hit), 32'd0);

    // Wrong minute: no hit
    set_time(7, 2, 8, 5, 9);
    tick_1hz = 1;
    step();
    tick_1hz = 0;
    check("alarm_wrong_min", 32'(alarm_hit), 32'd0);

    // Matching time in an alarm-set mode: no hit
    go_mode(3);
    set_time(7, 2, 9, 5, 9);
    tick_1hz = 1;
    step();
    tick_1hz = 0;
    check("alarm_not_run", 32'(alarm_hit), 32'd0);

    // Midnight rollover match 23:59:59 -> 00:00
    go_mode(0);
    alm_min = 6'd0; alm_hr = 5'd0;
    set_time(23, 5, 9, 5, 9);
    tick_1hz = 1;
    step();
    tick_1hz = 0;
    check("alarm_midnight", 32'(alarm_hit), 32'd1);

    // Reset while a hit is pending clears it
    go_mode(0);
    alm_min = 6'd30; alm_hr = 5'd7;
    set_time(7, 2, 9, 5, 9);
    tick_1hz = 1; rst = 1;
    step();
    tick_1hz = 0; rst = 0;
    check("rst_kills_alarm", 32'(alarm_hit), 32'd0);

    // Reset from a set mode returns to RUN
    go_mode(2);
    rst = 1;
    step();
    rst = 0;
    check("rst_mid_mode", 32'(mode), 32'(RUN));

    // Full mode cycle wraps back to RUN
    go_mode(5);
    check("mode_wrap", 32'(mode), 32'(RUN));

    alm_min = 6'd63; alm_hr = 5'd31;
`ifdef AUTO_EXIT_EN
    go_mode(1);
    for (int k = 0; k < 9; k++) tick_pulse();
    btn_up = 1;
    step();
    btn_up = 0;
    for (int k = 0; k < 9; k++) tick_pulse();
    check("idle_restart", 32'(mode), 32'(SET_MIN));
    tick_pulse();
    check("idle_exit", 32'(mode), 32'(RUN));
`else
    go_mode(1);
    for (int k = 0; k < 12; k++) tick_pulse();
    check("set_persist", 32'(mode), 32'(SET_MIN));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
